caf_xcorr_engine: RTL and testbench

- Parametrised successor to the single-shot CAF top.
- Holds a loadable complex reference buffer and a capture buffer, both with parametrised depth and I/Q width.
- After a capture, sweeps every time shift, computes the complex cross-correlation magnitude and returns the peak shift and magnitude as one AXI-stream beat.
- Sits between the sample-stream front end and the CAF frequency-bin logic; one instance per frequency channel.

---
 rtl/caf_xcorr_engine_if.sv | 27 ++
 rtl/caf_xcorr_engine.sv | 201 ++++++++++++++++++++
 tb/tb_caf_xcorr_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/caf_xcorr_engine_if.sv
// Stream bundle for caf_xcorr_engine.
//   m_axis_tdata/m_axis_tvalid : sample beats into the engine ({Q, I})
//   s_axis_tready              : engine accepts a sample beat
//   s_axis_tdata/s_axis_tvalid : result beat {peak_shift, peak_mag}
//   m_axis_tready              : downstream accepts the result beat
// slave is the engine side, master is the driving/consuming side.
interface caf_xcorr_engine_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 28
);
  logic [IN_W-1:0]  m_axis_tdata;
  logic             m_axis_tvalid;
  logic             s_axis_tready;
  logic [OUT_W-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             m_axis_tready;

  modport slave (
    input  m_axis_tdata, m_axis_tvalid, m_axis_tready,
    output s_axis_tready, s_axis_tdata, s_axis_tvalid
  );

  modport master (
    output m_axis_tdata, m_axis_tvalid, m_axis_tready,
    input  s_axis_tready, s_axis_tdata, s_axis_tvalid
  );
endinterface

// File: rtl/caf_xcorr_engine.sv
// Complex cross-correlation peak search for one CAF frequency channel.
// Loads a REF_LEN-sample reference, captures CAP_LEN samples, then sweeps
// every shift s computing sum_k cap[s+k]*conj(ref[k]); the shift with the
// largest |re|+|im| (lowest shift on ties) is returned as one result beat.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ref_load   : in IDLE, the next REF_LEN accepted beats load the reference
//   start      : in IDLE with ref_valid, capture CAP_LEN beats and correlate
//   ref_valid  : a complete reference is held
//   busy       : state is not IDLE
//   axis       : sample input and result output streams (slave modport)
module caf_xcorr_engine #(
  parameter int IQ_BITS = 8,
  parameter int REF_LEN = 16,
  parameter int CAP_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_load,
  input  logic start,
  output logic ref_valid,
  output logic busy,
  caf_xcorr_engine_if.slave axis
);
  localparam int NUM_SHIFTS = CAP_LEN - REF_LEN + 1;
  localparam int SHIFT_BITS = (NUM_SHIFTS > 1) ? $clog2(NUM_SHIFTS) : 1;
  localparam int ACC_BITS   = 2*IQ_BITS + 1 + $clog2(REF_LEN);
  localparam int MAG_BITS   = ACC_BITS + 1;
  localparam int OUT_BITS   = SHIFT_BITS + MAG_BITS;
  localparam int SAMP_W     = 2*IQ_BITS;
  localparam int PW         = 2*IQ_BITS + 1;
  localparam int CAP_AB     = $clog2(CAP_LEN);
  localparam int REF_AB     = $clog2(REF_LEN);
  localparam int PH_BITS    = $clog2(REF_LEN + 3);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_REF  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] CORRELATE = 3'd3;
  localparam logic [2:0] OUTPUT    = 3'd4;

  logic [2:0]            state;
  logic [CAP_AB-1:0]     ld_cnt;
  logic [SHIFT_BITS-1:0] shift;
  logic [PH_BITS-1:0]    ph;
  logic                  vld_p0, vld_p1;
  logic signed [ACC_BITS-1:0] acc_re, acc_im;
  logic [MAG_BITS-1:0]   peak_mag, mag;
  logic [SHIFT_BITS-1:0] peak_shift;
  logic                  res_vld;
  logic [OUT_BITS-1:0]   res_data;

  logic [SAMP_W-1:0] ref_mem [REF_LEN];
  logic [SAMP_W-1:0] cap_mem [CAP_LEN];
  logic [SAMP_W-1:0] cap_rd_p0, ref_rd_p0;
  logic signed [PW-1:0] pre_p1, pim_p1;
  logic signed [PW-1:0] ci_x, cq_x, ri_x, rq_x;

  logic              accept, rd_en;
  logic [CAP_AB-1:0] cap_addr;
  logic [REF_AB-1:0] ref_addr;

  // |v| widened by one bit so the most-negative accumulator value is exact.
  function automatic logic [MAG_BITS-1:0] abs_mag(input logic signed [ACC_BITS-1:0] v);
    logic signed [MAG_BITS-1:0] w;
    w = MAG_BITS'(v);
    return (w < 0) ? $unsigned(-w) : $unsigned(w);
  endfunction

  assign axis.s_axis_tready = (state == LOAD_REF) || (state == CAPTURE);
  assign axis.s_axis_tvalid = res_vld;
  assign axis.s_axis_tdata  = res_data;
  assign busy   = (state != IDLE);
  assign accept = axis.s_axis_tready && axis.m_axis_tvalid;

  // Reads are issued only for k < REF_LEN, so the address never leaves range.
  always_comb begin
    rd_en    = (state == CORRELATE) && (ph < PH_BITS'(REF_LEN));
    cap_addr = '0;
    ref_addr = '0;
    if (rd_en) begin
      cap_addr = CAP_AB'(shift) + CAP_AB'(ph);
      ref_addr = REF_AB'(ph);
    end
  end

  always_comb begin
    ci_x = PW'($signed(cap_rd_p0[IQ_BITS-1:0]));
    cq_x = PW'($signed(cap_rd_p0[SAMP_W-1:IQ_BITS]));
    ri_x = PW'($signed(ref_rd_p0[IQ_BITS-1:0]));
    rq_x = PW'($signed(ref_rd_p0[SAMP_W-1:IQ_BITS]));
    mag  = abs_mag(acc_re) + abs_mag(acc_im);
  end

  always_ff @(posedge clk) begin
    if (accept && state == LOAD_REF) ref_mem[REF_AB'(ld_cnt)] <= axis.m_axis_tdata;
    if (accept && state == CAPTURE)  cap_mem[ld_cnt]          <= axis.m_axis_tdata;
  end

  // Stage p0: memory read
  always_ff @(posedge clk) begin
    if (rd_en) begin
      cap_rd_p0 <= cap_mem[cap_addr];
      ref_rd_p0 <= ref_mem[ref_addr];
    end
    // Stage p1: cap * conj(ref) product
    pre_p1 <= ci_x*ri_x + cq_x*rq_x;
    pim_p1 <= cq_x*ri_x - ci_x*rq_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ref_valid  <= 1'b0;
      ld_cnt     <= '0;
      shift      <= '0;
      ph         <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      acc_re     <= '0;
      acc_im     <= '0;
      peak_mag   <= '0;
      peak_shift <= '0;
      res_vld    <= 1'b0;
      res_data   <= '0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      // Stage p2: accumulate
      if (vld_p1) begin
        acc_re <= acc_re + ACC_BITS'(pre_p1);
        acc_im <= acc_im + ACC_BITS'(pim_p1);
      end
      case (state)
        IDLE: begin
          if (ref_load) begin
            state     <= LOAD_REF;
            ref_valid <= 1'b0;
            ld_cnt    <= '0;
          end else if (start && ref_valid) begin
            state  <= CAPTURE;
            ld_cnt <= '0;
          end
        end
        LOAD_REF: begin
          if (accept) begin
            if (ld_cnt == CAP_AB'(REF_LEN-1)) begin
              ref_valid <= 1'b1;
              ld_cnt    <= '0;
              state     <= IDLE;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (ld_cnt == CAP_AB'(CAP_LEN-1)) begin
              ld_cnt <= '0;
              shift  <= '0;
              ph     <= '0;
              state  <= CORRELATE;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        CORRELATE: begin
          // Last phase of a shift: all products are in, compare then clear.
          if (ph == PH_BITS'(REF_LEN+2)) begin
            ph     <= '0;
            acc_re <= '0;
            acc_im <= '0;
            if (shift == '0 || mag > peak_mag) begin
              peak_mag   <= mag;
              peak_shift <= shift;
            end
            if (shift == SHIFT_BITS'(NUM_SHIFTS-1)) begin
              shift <= '0;
              state <= OUTPUT;
            end else begin
              shift <= shift + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        OUTPUT: begin
          if (!res_vld) begin
            res_vld  <= 1'b1;
            res_data <= {peak_shift, peak_mag};
          end else if (axis.m_axis_tready) begin
            res_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_caf_xcorr_engine.sv
module tb_caf_xcorr_engine;
  localparam int IQ_BITS    = 8;
  localparam int REF_LEN    = 4;
  localparam int CAP_LEN    = 8;
  localparam int NUM_SHIFTS = 5;
  localparam int SHIFT_BITS = 3;
  localparam int MAG_BITS   = 20;
  localparam int OUT_W      = 23;
  localparam int LAT        = 36;

  logic clk = 1'b0;
  logic rst, ref_load, start;
  logic ref_valid, busy;
  int tests = 0;
  int fails = 0;

  logic [15:0] ref_buf [REF_LEN];
  logic [15:0] cap_buf [CAP_LEN];

  caf_xcorr_engine_if #(.IN_W(16), .OUT_W(OUT_W)) axis ();

  caf_xcorr_engine #(.IQ_BITS(IQ_BITS), .REF_LEN(REF_LEN), .CAP_LEN(CAP_LEN)) dut (
    .clk(clk), .rst(rst), .ref_load(ref_load), .start(start),
    .ref_valid(ref_valid), .busy(busy), .axis(axis)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] iq(input int i, input int q);
    return {q[7:0], i[7:0]};
  endfunction

  // Direct evaluation of the correlation sum over all shifts.
  function automatic logic [OUT_W-1:0] model();
    longint best, re, im, m;
    int bs, ci, cq, ri, rq;
    logic [15:0] c, r;
    best = 0; bs = 0;
    for (int s = 0; s < NUM_SHIFTS; s++) begin
      re = 0; im = 0;
      for (int k = 0; k < REF_LEN; k++) begin
        c = cap_buf[s+k]; r = ref_buf[k];
        ci = int'($signed(c[7:0])); cq = int'($signed(c[15:8]));
        ri = int'($signed(r[7:0])); rq = int'($signed(r[15:8]));
        re += longint'(ci*ri + cq*rq);
        im += longint'(cq*ri - ci*rq);
      end
      m = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      if (s == 0 || m > best) begin best = m; bs = s; end
    end
    return {bs[SHIFT_BITS-1:0], best[MAG_BITS-1:0]};
  endfunction

  task automatic send_beat(input logic [15:0] d, input bit gap);
    int n;
    n = 0;
    if (gap) begin axis.m_axis_tvalid = 1'b0; @(negedge clk); end
    axis.m_axis_tvalid = 1'b1;
    axis.m_axis_tdata  = d;
    while (!axis.s_axis_tready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL beat_accept: tready stayed %b, required 1", axis.s_axis_tready);
    end
    @(negedge clk);
    axis.m_axis_tvalid = 1'b0;
  endtask

  task automatic load_ref(input bit gapped);
    @(negedge clk); ref_load = 1'b1;
    @(negedge clk); ref_load = 1'b0;
    for (int n = 0; n < REF_LEN; n++) send_beat(ref_buf[n], gapped);
  endtask

  task automatic run_capture(input logic [OUT_W-1:0] exp, input int hold, input string nm);
    int cyc;
    logic [OUT_W-1:0] held;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < CAP_LEN; n++) send_beat(cap_buf[n], 1'b0);
    cyc = 0;
    while (!axis.s_axis_tvalid && cyc < 200) begin @(negedge clk); cyc++; end
    tests++;
    if (cyc !== LAT) begin
      fails++; $display("FAIL %s latency: got %0d cycles, required %0d", nm, cyc, LAT);
    end
    tests++;
    if (axis.s_axis_tdata !== exp) begin
      fails++; $display("FAIL %s result: got shift=%0d mag=%0d, required shift=%0d mag=%0d", nm,
        axis.s_axis_tdata[OUT_W-1:MAG_BITS], axis.s_axis_tdata[MAG_BITS-1:0],
        exp[OUT_W-1:MAG_BITS], exp[MAG_BITS-1:0]);
    end
    held = axis.s_axis_tdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests++;
      if (axis.s_axis_tvalid !== 1'b1 || axis.s_axis_tdata !== held) begin
        fails++; $display("FAIL %s hold%0d: got tvalid=%b tdata=%h, required 1 / %h", nm, h,
          axis.s_axis_tvalid, axis.s_axis_tdata, held);
      end
    end
    axis.m_axis_tready = 1'b1;
    @(negedge clk);
    axis.m_axis_tready = 1'b0;
    tests++;
    if (axis.s_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s handshake: got tvalid=%b busy=%b, required 0/0", nm,
        axis.s_axis_tvalid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ref_load = 1'b0; start = 1'b0;
    axis.m_axis_tvalid = 1'b0; axis.m_axis_tdata = '0; axis.m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (axis.s_axis_tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %b, required 0", axis.s_axis_tready); end
    tests++; if (axis.s_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b, required 0", axis.s_axis_tvalid); end
    tests++; if (axis.s_axis_tdata !== '0) begin fails++; $display("FAIL rst_tdata: got %h, required 0", axis.s_axis_tdata); end
    tests++; if (ref_valid !== 1'b0) begin fails++; $display("FAIL rst_ref_valid: got %b, required 0", ref_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (busy !== 1'b0 || axis.s_axis_tready !== 1'b0) begin
        fails++; $display("FAIL start_no_ref: got busy=%b tready=%b, required 0/0", busy, axis.s_axis_tready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ref_load();
    for (int k = 0; k < REF_LEN; k++) ref_buf[k] = iq(1, 0);
    @(negedge clk); ref_load = 1'b1;
    @(negedge clk); ref_load = 1'b0;
    tests++;
    if (busy !== 1'b1 || axis.s_axis_tready !== 1'b1) begin
      fails++; $display("FAIL load_state: got busy=%b tready=%b, required 1/1", busy, axis.s_axis_tready);
    end
    for (int n = 0; n < REF_LEN; n++) begin
      send_beat(ref_buf[n], 1'b1);
      if (n == REF_LEN-2) begin
        tests++;
        if (ref_valid !== 1'b0) begin fails++; $display("FAIL load_early: got ref_valid=%b, required 0", ref_valid); end
      end
    end
    tests++;
    if (ref_valid !== 1'b1 || axis.s_axis_tready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL load_done: got ref_valid=%b tready=%b busy=%b, required 1/0/0",
        ref_valid, axis.s_axis_tready, busy);
    end
  endtask

  task automatic test_real_peak();
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = (n >= 3 && n <= 6) ? iq(10, 0) : 16'h0;
    run_capture({3'd3, 20'd40}, 0, "real_peak");
  endtask

  task automatic test_complex();
    for (int k = 0; k < REF_LEN; k++) ref_buf[k] = (k == 0) ? iq(0, 5) : 16'h0;
    load_ref(1'b0);
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = (n == 2) ? iq(0, 5) : 16'h0;
    run_capture({3'd2, 20'd25}, 0, "complex_conj");
  endtask

  task automatic test_extremes();
    for (int k = 0; k < REF_LEN; k++) ref_buf[k] = iq(-128, -128);
    load_ref(1'b0);
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = iq(-128, -128);
    run_capture({3'd0, 20'd131072}, 0, "extreme_tie");
  endtask

  task automatic test_zero_capture();
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = 16'h0;
    run_capture({3'd0, 20'd0}, 0, "zero_capture");
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < REF_LEN; k++) ref_buf[k] = 16'($urandom);
      load_ref(it[0]);
      for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = 16'($urandom);
      run_capture(model(), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = 16'($urandom);
    run_capture(model(), 10, "backpressure");
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = 16'($urandom);
    run_capture(model(), 0, "back_to_back");
  endtask

  task automatic test_reset_mid_correlate();
    int seen;
    for (int n = 0; n < CAP_LEN; n++) cap_buf[n] = 16'($urandom);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < CAP_LEN; n++) send_beat(cap_buf[n], 1'b0);
    repeat (10) @(negedge clk);
    axis.m_axis_tready = 1'b1;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || ref_valid !== 1'b0 || axis.s_axis_tvalid !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got busy=%b ref_valid=%b tvalid=%b, required 0/0/0",
        busy, ref_valid, axis.s_axis_tvalid);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (axis.s_axis_tvalid === 1'b1) seen++;
    end
    axis.m_axis_tready = 1'b0;
    tests++;
    if (seen !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset_no_result: got %0d result cycles busy=%b, required 0/0", seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ref_load();
    test_real_peak();
    test_complex();
    test_extremes();
    test_zero_capture();
    test_random(6);
    test_back_to_back();
    test_reset_mid_correlate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
